// File: rtl/conv_result_reader.sv
// Drains the accumulation RAM row-major onto a valid/ready stream, absorbing the RAM read latency.
// Optional macro RELU_EN clamps negative result words to zero before buffering.
module conv_result_reader #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddrWidth    = 16,
    parameter int unsigned MaxPictWidth = 9,
    parameter int unsigned RdLatency    = 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    start,
    input  logic [MaxPictWidth-1:0] row_in,
    input  logic [MaxPictWidth-1:0] col_in,
    input  logic [AddrWidth-1:0]    base_addr,
    output logic [AddrWidth-1:0]    rd_addr_out,
    input  logic [DataWidth-1:0]    rd_data_in,
    output logic [DataWidth-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_row_last,
    output logic                    out_frame_last,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned Depth = RdLatency + 1;
    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned TotW  = 2 * MaxPictWidth;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [TotW-1:0]         total_q, idx_q;
    logic [MaxPictWidth-1:0] col_q, col_cnt_q;
    logic [AddrWidth-1:0]    addr_q;
    logic [RdLatency-1:0]    tag_q, rlast_sr_q, flast_sr_q;
    logic [DataWidth-1:0]    mem_q [Depth];
    logic                    rlast_mem_q [Depth];
    logic                    flast_mem_q [Depth];
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]         count_q, inflight;
    logic [CntW:0]           occ;
    logic                    credit_ok, issue, push, pop;
    logic                    row_last_iss, frame_last_iss;
    logic [DataWidth-1:0]    push_data;

`ifdef RELU_EN
    assign push_data = rd_data_in[DataWidth-1] ? '0 : rd_data_in;
`else
    assign push_data = rd_data_in;
`endif

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RdLatency; i++) begin
            inflight = inflight + CntW'(tag_q[i]);
        end
    end

    // A pop this cycle frees a slot, which keeps 1 word/cycle with the minimum buffer depth.
    assign occ            = {1'b0, inflight} + {1'b0, count_q};
    assign credit_ok      = occ < ((CntW + 1)'(Depth) + (CntW + 1)'(pop));
    assign issue          = (state_q == StRead) && (idx_q < total_q) && credit_ok;
    assign push           = tag_q[RdLatency-1];
    assign out_valid      = (count_q != '0);
    assign pop            = out_valid && out_ready;
    assign row_last_iss   = (col_cnt_q == col_q - MaxPictWidth'(1));
    assign frame_last_iss = (idx_q == total_q - TotW'(1));

    assign rd_addr_out    = addr_q;
    assign out_data       = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_row_last   = out_valid ? rlast_mem_q[rd_ptr_q] : 1'b0;
    assign out_frame_last = out_valid ? flast_mem_q[rd_ptr_q] : 1'b0;
    assign busy           = (state_q == StRead) || (state_q == StDrain);
    assign done           = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRead;
            StRead: begin
                if (total_q == '0) begin
                    state_d = StDone;
                end else if (issue && frame_last_iss) begin
                    state_d = StDrain;
                end
            end
            // Exit on the edge that empties both the pipeline and the buffer.
            StDrain: begin
                if ((inflight == CntW'(push)) && ((count_q + CntW'(push)) == CntW'(pop))) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= StIdle;
            total_q    <= '0;
            idx_q      <= '0;
            col_q      <= '0;
            col_cnt_q  <= '0;
            addr_q     <= '0;
            tag_q      <= '0;
            rlast_sr_q <= '0;
            flast_sr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && start) begin
                total_q   <= TotW'(row_in) * TotW'(col_in);
                col_q     <= col_in;
                idx_q     <= '0;
                col_cnt_q <= '0;
                addr_q    <= base_addr;
            end else if (issue) begin
                idx_q     <= idx_q + TotW'(1);
                addr_q    <= addr_q + AddrWidth'(1);
                col_cnt_q <= row_last_iss ? '0 : col_cnt_q + MaxPictWidth'(1);
            end
            tag_q      <= RdLatency'({tag_q, issue});
            rlast_sr_q <= RdLatency'({rlast_sr_q, row_last_iss});
            flast_sr_q <= RdLatency'({flast_sr_q, frame_last_iss});
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q]       <= push_data;
            rlast_mem_q[wr_ptr_q] <= rlast_sr_q[RdLatency-1];
            flast_mem_q[wr_ptr_q] <= flast_sr_q[RdLatency-1];
        end
    end

endmodule

// File: tb/tb_conv_result_reader.sv
// Randomised bench for conv_result_reader: a queue of expected words built from map geometry
// and a RAM content function, compared against the stream on every valid cycle.
module tb_conv_result_reader;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  row_in = '0;
    logic [8:0]  col_in = '0;
    logic [15:0] base_addr = '0;
    logic [15:0] rd_addr_out;
    logic [31:0] rd_data_in;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_row_last;
    logic        out_frame_last;
    logic        busy;
    logic        done;

    conv_result_reader dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .start          (start),
        .row_in         (row_in),
        .col_in         (col_in),
        .base_addr      (base_addr),
        .rd_addr_out    (rd_addr_out),
        .rd_data_in     (rd_data_in),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_row_last   (out_row_last),
        .out_frame_last (out_frame_last),
        .busy           (busy),
        .done           (done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] data;
        logic        rl;
        logic        fl;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          xfer_cnt = 0;
    logic [31:0] ram_mul = 32'd3;
    logic [31:0] ram_add = 32'hFFFFFFCE;
    logic        zero_mode = 1'b0;
    logic        done_exp = 1'b0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word = '0;

    function automatic logic [31:0] ram_fn(input logic [15:0] a);
        return ram_mul * {16'h0, a} + ram_add;
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    // RAM with a one-cycle registered read port.
    always @(posedge Clk) rd_data_in <= ram_fn(rd_addr_out);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst) begin
            done_exp   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            logic next_done;
            next_done = 1'b0;
            if (!zero_mode) check("done_pulse", done, done_exp);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_word", {out_data, out_row_last, out_frame_last}, prev_word);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", out_valid, 1'b0);
                end else begin
                    check("word", {out_data, out_row_last, out_frame_last},
                          {exp_q[0].data, exp_q[0].rl, exp_q[0].fl});
                    if (out_ready) begin
                        next_done = exp_q[0].fl;
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_data, out_row_last, out_frame_last};
            done_exp   = next_done;
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic start_job(input int r, input int c, input logic [15:0] base);
        tick;
        row_in    = 9'(r);
        col_in    = 9'(c);
        base_addr = base;
        for (int i = 0; i < r * c; i++) begin
            exp_t e;
            e.data = relu(ram_fn(base + 16'(i)));
            e.rl   = ((i % c) == c - 1);
            e.fl   = (i == r * c - 1);
            exp_q.push_back(e);
        end
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            tick;
            n++;
        end
        if (!done) check(name, 1'b0, 1'b1);
    endtask

    // mode 0: ready high, 1: 1,0,1,0.. then 10 low, 2: random
    task automatic run_job(input int r, input int c, input logic [15:0] base, input int mode,
                           input int mid, output int first_k, output int done_k,
                           output logic [33:0] first_word);
        int k;
        first_k = -1;
        done_k  = -1;
        first_word = '0;
        start_job(r, c, base);
        k = 1;
        while (done_k < 0 && k < 3000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k < 8) ? (k % 2 == 1) : (k >= 18);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (k == mid && busy) begin
                start     = 1'b1;
                row_in    = 9'd3;
                col_in    = 9'd2;
                base_addr = 16'h5555;
            end
            if (out_valid && first_k < 0) begin
                first_k    = k;
                first_word = {out_data, out_row_last, out_frame_last};
            end
            tick;
            start = 1'b0;
            k++;
            if (done) done_k = k;
        end
        out_ready = 1'b1;
        check("job_done_seen", (done_k > 0), 1'b1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int          fk, dk, x0;
        logic [33:0] fw;

        tick;
        tick;
        Rst = 1'b0;
        check("rst_addr", rd_addr_out, 16'h0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 32'h0);
        check("rst_flags", {out_row_last, out_frame_last}, 2'b00);
        check("rst_busy_done", {busy, done}, 2'b00);

        // 6x6, RAM[a]=3a-50, ready held high.
        x0 = xfer_cnt;
        run_job(6, 6, 16'h0000, 0, 0, fk, dk, fw);
        check("t1_first_valid_cycle", fk, 3);
        check("t1_done_cycle", dk, 39);
`ifdef RELU_EN
        check("t1_first_word", fw, {32'h0, 2'b00});
`else
        check("t1_first_word", fw, {32'hFFFFFFCE, 2'b00});
`endif
        check("t1_transfers", xfer_cnt - x0, 36);

        // Patterned backpressure with a start pulsed mid-drain.
        run_job(6, 6, 16'h0000, 1, 6, fk, dk, fw);

        // Empty map: no output, done two cycles after start.
        zero_mode = 1'b1;
        start_job(0, 6, 16'h0040);
        check("t3_busy_c1", busy, 1'b1);
        check("t3_done_c1", done, 1'b0);
        tick;
        check("t3_busy_c2", busy, 1'b0);
        check("t3_done_c2", done, 1'b1);
        tick;
        check("t3_done_c3", done, 1'b0);
        zero_mode = 1'b0;

        // Address wrap at the top of the RAM.
        ram_mul = 32'd7;
        ram_add = 32'd11;
        start_job(2, 2, 16'hFFFE);
        check("t4_addr0", rd_addr_out, 16'hFFFE);
        tick;
        check("t4_addr1", rd_addr_out, 16'hFFFF);
        tick;
        check("t4_addr2", rd_addr_out, 16'h0000);
        tick;
        check("t4_addr3", rd_addr_out, 16'h0001);
        wait_done("t4_done_timeout");

        // Reset one cycle after the 10th transfer, then a clean rerun.
        x0 = xfer_cnt;
        start_job(6, 6, 16'h0100);
        for (int n = 0; n < 200 && xfer_cnt < x0 + 10; n++) tick;
        check("t5_reached_10", (xfer_cnt >= x0 + 10), 1'b1);
        Rst = 1'b1;
        exp_q.delete();
        tick;
        check("t5_valid", out_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_addr", rd_addr_out, 16'h0);
        Rst = 1'b0;
        x0 = xfer_cnt;
        run_job(6, 6, 16'h0100, 0, 0, fk, dk, fw);
        check("t5_rerun_transfers", xfer_cnt - x0, 36);

        // Single negative word.
        ram_mul = 32'd5;
        ram_add = 32'hFFFFFFF9;
        run_job(1, 1, 16'h0000, 0, 0, fk, dk, fw);
`ifdef RELU_EN
        check("t6_word", fw, {32'h0, 2'b11});
`else
        check("t6_word", fw, {32'hFFFFFFF9, 2'b11});
`endif

        for (int j = 0; j < 10; j++) begin
            ram_mul = $urandom | 32'd1;
            ram_add = $urandom;
            run_job($urandom_range(1, 6), $urandom_range(1, 6), 16'($urandom), 2,
                    $urandom_range(1, 2), fk, dk, fw);
        end

        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
